// File: rtl/cpu7_ifu_fetch_ctl.sv
// Instruction fetch control: issues fetch requests, tracks in-flight
// responses, squashes stale ones after a redirect, buffers for decode.
module cpu7_ifu_fetch_ctl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_init,
    input  logic        exu_ifu_except,
    input  logic [31:0] exu_ifu_eentry,
    input  logic        exu_ifu_ertn_e,
    input  logic [31:0] exu_ifu_era,
    input  logic        exu_ifu_br_taken,
    input  logic [31:0] exu_ifu_br_target,
    input  logic        exu_ifu_stall_req,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    output logic        inst_cancel,
    input  logic        inst_valid_f,
    input  logic [31:0] inst_rdata_f,
    output logic        fetch_vld_f,
    output logic [31:0] fetch_inst_f,
    output logic [31:0] fetch_pc_f
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] fetch_pc;
    logic [1:0]  outstanding;
    logic [1:0]  drop_cnt;
    logic [1:0]  drop_next;

    logic        redirect;
    logic [31:0] redir_tgt;
    logic        accept;
    logic        rsp_vld;
    logic        rsp_keep;
    logic        rsp_drop;

    logic [31:0] pcq_mem [2];
    logic        pcq_wr;
    logic        pcq_rd;

    logic [31:0] fifo_pc  [2];
    logic [31:0] fifo_ins [2];
    logic        fifo_wr;
    logic        fifo_rd;
    logic [1:0]  fifo_cnt;
    logic        fifo_pop;

    // Redirect arbitration: exception beats ertn beats taken branch
    always_comb begin
        redirect  = exu_ifu_except | exu_ifu_ertn_e | exu_ifu_br_taken;
        redir_tgt = exu_ifu_br_target;
        if (exu_ifu_except) begin
            redir_tgt = exu_ifu_eentry;
        end else if (exu_ifu_ertn_e) begin
            redir_tgt = exu_ifu_era;
        end
    end

    assign accept    = inst_req & inst_addr_ok;
    assign rsp_vld   = inst_valid_f & (outstanding != 2'd0);
    assign rsp_keep  = rsp_vld & ~redirect & (drop_cnt == 2'd0);
    assign rsp_drop  = rsp_vld & ~redirect & (drop_cnt != 2'd0);
    assign drop_next = outstanding - {1'b0, rsp_vld};
    assign fifo_pop  = fetch_vld_f & ~exu_ifu_stall_req;

    assign inst_addr    = fetch_pc;
    assign fetch_vld_f  = (fifo_cnt != 2'd0);
    assign fetch_pc_f   = fifo_pc[fifo_rd];
    assign fetch_inst_f = fifo_ins[fifo_rd];

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: stay in FLUSH until every stale response is gone
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect && drop_next != 2'd0) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (redirect) begin
                    state_d = (drop_next == 2'd0) ? RUN : FLUSH;
                end else if (rsp_drop && drop_cnt == 2'd1) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // FSM outputs: request only with a free credit, cancel on redirect
    always_comb begin
        inst_req = (state_q == RUN) & ~redirect &
                   (({1'b0, outstanding} + {1'b0, fifo_cnt}) < 3'd2);
        inst_cancel = redirect & ~reset;
    end

    // Fetch PC: redirect wins, boot loads pc_init, accept advances
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= 32'd0;
        end else if (redirect) begin
            fetch_pc <= redir_tgt;
        end else if (state_q == BOOT) begin
            fetch_pc <= pc_init;
        end else if (accept) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // In-flight and drop counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= 2'd0;
            drop_cnt    <= 2'd0;
        end else begin
            outstanding <= outstanding + {1'b0, accept} - {1'b0, rsp_vld};
            if (redirect) begin
                drop_cnt <= drop_next;
            end else if (rsp_drop) begin
                drop_cnt <= drop_cnt - 2'd1;
            end
        end
    end

    // PC queue holds addresses of live requests only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcq_mem[0] <= 32'd0;
            pcq_mem[1] <= 32'd0;
            pcq_wr     <= 1'b0;
            pcq_rd     <= 1'b0;
        end else if (redirect) begin
            pcq_wr <= 1'b0;
            pcq_rd <= 1'b0;
        end else begin
            if (accept) begin
                pcq_mem[pcq_wr] <= fetch_pc;
                pcq_wr          <= ~pcq_wr;
            end
            if (rsp_keep) begin
                pcq_rd <= ~pcq_rd;
            end
        end
    end

    // Output FIFO towards decode, emptied on redirect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_pc[0]  <= 32'd0;
            fifo_pc[1]  <= 32'd0;
            fifo_ins[0] <= 32'd0;
            fifo_ins[1] <= 32'd0;
            fifo_wr     <= 1'b0;
            fifo_rd     <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else if (redirect) begin
            fifo_wr  <= 1'b0;
            fifo_rd  <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (rsp_keep) begin
                fifo_pc[fifo_wr]  <= pcq_mem[pcq_rd];
                fifo_ins[fifo_wr] <= inst_rdata_f;
                fifo_wr           <= ~fifo_wr;
            end
            if (fifo_pop) begin
                fifo_rd <= ~fifo_rd;
            end
            fifo_cnt <= fifo_cnt + {1'b0, rsp_keep} - {1'b0, fifo_pop};
        end
    end

endmodule

// File: tb/tb_cpu7_ifu_fetch_ctl.sv
// Randomized bench for cpu7_ifu_fetch_ctl against a queue-based model
// of the fetch pipeline and an in-order memory with random latency.
module tb_cpu7_ifu_fetch_ctl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_init = 32'd0;
    logic        exu_ifu_except = 1'b0;
    logic [31:0] exu_ifu_eentry = 32'd0;
    logic        exu_ifu_ertn_e = 1'b0;
    logic [31:0] exu_ifu_era = 32'd0;
    logic        exu_ifu_br_taken = 1'b0;
    logic [31:0] exu_ifu_br_target = 32'd0;
    logic        exu_ifu_stall_req = 1'b0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_cancel;
    logic        inst_valid_f = 1'b0;
    logic [31:0] inst_rdata_f = 32'd0;
    logic        fetch_vld_f;
    logic [31:0] fetch_inst_f;
    logic [31:0] fetch_pc_f;

    always #5 clk = ~clk;

    cpu7_ifu_fetch_ctl dut (
        .clk               (clk),
        .reset             (reset),
        .pc_init           (pc_init),
        .exu_ifu_except    (exu_ifu_except),
        .exu_ifu_eentry    (exu_ifu_eentry),
        .exu_ifu_ertn_e    (exu_ifu_ertn_e),
        .exu_ifu_era       (exu_ifu_era),
        .exu_ifu_br_taken  (exu_ifu_br_taken),
        .exu_ifu_br_target (exu_ifu_br_target),
        .exu_ifu_stall_req (exu_ifu_stall_req),
        .inst_req          (inst_req),
        .inst_addr         (inst_addr),
        .inst_addr_ok      (inst_addr_ok),
        .inst_cancel       (inst_cancel),
        .inst_valid_f      (inst_valid_f),
        .inst_rdata_f      (inst_rdata_f),
        .fetch_vld_f       (fetch_vld_f),
        .fetch_inst_f      (fetch_inst_f),
        .fetch_pc_f        (fetch_pc_f)
    );

    typedef struct {
        logic [31:0] pc;
        bit          stale;
    } fl_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ob_t;

    // model: requests in flight (oldest first) and decode-side buffer
    fl_t         m_inf[$];
    ob_t         m_out[$];
    bit          m_boot;
    logic [31:0] m_pc;

    // memory: accepted addresses with the cycle they may answer
    logic [31:0] mem_addr[$];
    int          mem_rdy[$];
    int          cyc;

    // logs
    logic [31:0] dlv[$];
    logic [31:0] accq[$];
    int          drops;
    int          fire_idx;
    bit          fired;

    // stimulus knobs
    int          p_stall;
    int          p_ok;
    int          p_redir;
    int          lat_min;
    int          lat_max;
    bit          force_br2;
    bit          force_exc;
    logic [31:0] force_tgt;

    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    function automatic bit any_stale();
        foreach (m_inf[i]) begin
            if (m_inf[i].stale) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_inf.delete();
        m_out.delete();
        mem_addr.delete();
        mem_rdy.delete();
        dlv.delete();
        accq.delete();
        m_boot = 1'b1;
        m_pc   = 32'd0;
    endtask

    // one cycle: drive at negedge, compare, advance the model
    task automatic step();
        bit          r;
        logic [31:0] tgt;
        bit          e_req;
        bit          rsp;
        bit          acc;
        bit          pop_out;
        fl_t         f;
        ob_t         o;

        exu_ifu_stall_req = ($urandom_range(99) < p_stall);
        inst_addr_ok      = ($urandom_range(99) < p_ok);
        exu_ifu_except    = 1'b0;
        exu_ifu_ertn_e    = 1'b0;
        exu_ifu_br_taken  = 1'b0;
        exu_ifu_eentry    = $urandom() & 32'hFFFF_FFFC;
        exu_ifu_era       = $urandom() & 32'hFFFF_FFFC;
        exu_ifu_br_target = $urandom() & 32'hFFFF_FFFC;
        if (force_exc) begin
            force_exc         = 1'b0;
            exu_ifu_except    = 1'b1;
            exu_ifu_eentry    = 32'h1C00_8000;
            exu_ifu_br_taken  = 1'b1;
            exu_ifu_br_target = 32'h1C00_0200;
        end else if (force_br2 && !m_boot && m_inf.size() == 2) begin
            force_br2         = 1'b0;
            fired             = 1'b1;
            exu_ifu_br_taken  = 1'b1;
            exu_ifu_br_target = force_tgt;
        end else if ($urandom_range(99) < p_redir) begin
            exu_ifu_except   = $urandom_range(1);
            exu_ifu_ertn_e   = $urandom_range(1);
            exu_ifu_br_taken = $urandom_range(1);
        end

        inst_valid_f = 1'b0;
        inst_rdata_f = $urandom();
        if (mem_addr.size() > 0) begin
            if (mem_rdy[0] <= cyc) begin
                inst_valid_f = 1'b1;
                inst_rdata_f = hash(mem_addr[0]);
                void'(mem_addr.pop_front());
                void'(mem_rdy.pop_front());
            end
        end else begin
            inst_valid_f = ($urandom_range(9) == 0);
        end

        #1;
        r   = exu_ifu_except | exu_ifu_ertn_e | exu_ifu_br_taken;
        tgt = exu_ifu_except ? exu_ifu_eentry :
              exu_ifu_ertn_e ? exu_ifu_era : exu_ifu_br_target;
        e_req = !m_boot && !r && !any_stale() &&
                (m_inf.size() + m_out.size() < 2);

        chk("inst_req", inst_req, e_req);
        chk("inst_addr", inst_addr, m_pc);
        chk("inst_cancel", inst_cancel, r);
        chk("fetch_vld_f", fetch_vld_f, m_out.size() > 0);
        if (m_out.size() > 0) begin
            chk("fetch_pc_f", fetch_pc_f, m_out[0].pc);
            chk("fetch_inst_f", fetch_inst_f, m_out[0].inst);
        end

        rsp     = inst_valid_f && m_inf.size() > 0;
        acc     = e_req && inst_addr_ok;
        pop_out = m_out.size() > 0 && !exu_ifu_stall_req;

        if (acc) begin
            mem_addr.push_back(m_pc);
            mem_rdy.push_back(cyc + $urandom_range(lat_max, lat_min));
            accq.push_back(m_pc);
        end
        if (pop_out) begin
            o = m_out.pop_front();
            dlv.push_back(o.pc);
        end
        if (r && fired && exu_ifu_br_taken && tgt == force_tgt) begin
            fire_idx = dlv.size();
            drops    = 0;
        end

        if (m_boot) begin
            m_pc   = r ? tgt : pc_init;
            m_boot = 1'b0;
        end else if (r) begin
            m_pc = tgt;
            if (rsp) begin
                void'(m_inf.pop_front());
                drops++;
            end
            foreach (m_inf[i]) m_inf[i].stale = 1'b1;
            m_out.delete();
        end else begin
            if (rsp) begin
                f = m_inf.pop_front();
                if (f.stale) begin
                    drops++;
                end else begin
                    o.pc   = f.pc;
                    o.inst = inst_rdata_f;
                    m_out.push_back(o);
                end
            end
            if (acc) begin
                f.pc    = m_pc;
                f.stale = 1'b0;
                m_inf.push_back(f);
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // assert reset mid-cycle, check outputs clear at once, release
    task automatic do_reset(input logic [31:0] pc);
        @(negedge clk);
        reset             = 1'b1;
        exu_ifu_except    = 1'b1;
        exu_ifu_eentry    = 32'h1234_5678;
        inst_valid_f      = 1'b0;
        #1;
        chk("rst_inst_req", inst_req, 1'b0);
        chk("rst_inst_cancel", inst_cancel, 1'b0);
        chk("rst_fetch_vld", fetch_vld_f, 1'b0);
        chk("rst_inst_addr", inst_addr, 32'd0);
        chk("rst_fetch_inst", fetch_inst_f, 32'd0);
        chk("rst_fetch_pc", fetch_pc_f, 32'd0);
        model_clear();
        pc_init = pc;
        repeat (2) @(negedge clk);
        exu_ifu_except = 1'b0;
        reset          = 1'b0;
    endtask

    task automatic set_knobs(input int st, input int ok, input int rd,
                             input int lmin, input int lmax);
        p_stall = st;
        p_ok    = ok;
        p_redir = rd;
        lat_min = lmin;
        lat_max = lmax;
    endtask

    initial begin
        int n;
        bool_loop: begin end
        cyc       = 0;
        force_br2 = 1'b0;
        force_exc = 1'b0;
        fired     = 1'b0;
        fire_idx  = 0;
        drops     = 0;
        force_tgt = 32'h1C00_0100;

        // boot, always-ready memory, 1-cycle latency
        set_knobs(0, 100, 0, 1, 1);
        do_reset(32'h1C00_0000);
        run(12);
        chk("boot_acc0", accq[0], 32'h1C00_0000);
        chk("boot_acc1", accq[1], 32'h1C00_0004);
        chk("boot_dlv0", dlv[0], 32'h1C00_0000);
        chk("boot_dlv1", dlv[1], 32'h1C00_0004);
        chk("boot_dlv2", dlv[2], 32'h1C00_0008);

        // decode backpressure for 5 cycles
        set_knobs(100, 100, 0, 1, 1);
        run(5);
        chk("stall_req_low", inst_req, 1'b0);
        chk("stall_vld", fetch_vld_f, 1'b1);
        chk("stall_fifo_full", m_out.size(), 2);
        set_knobs(0, 100, 0, 1, 1);
        run(10);
        for (int i = 0; i + 1 < dlv.size(); i++) begin
            chk("seq_contig", dlv[i + 1], dlv[i] + 32'd4);
        end

        // branch redirect with two requests in flight
        set_knobs(0, 100, 0, 3, 3);
        fired     = 1'b0;
        force_br2 = 1'b1;
        run(25);
        chk("br_fired", fired, 1'b1);
        chk("br_drops", drops, 2);
        n = (fire_idx < dlv.size()) ? fire_idx : 0;
        chk("br_first_pc", dlv[n], 32'h1C00_0100);

        // exception and branch together: exception target wins
        force_exc = 1'b1;
        run(1);
        chk("prio_addr", inst_addr, 32'h1C00_8000);
        run(10);

        // random traffic
        set_knobs(30, 60, 5, 1, 4);
        run(3000);

        // PC wraps past the top of the address space
        set_knobs(0, 100, 0, 1, 1);
        do_reset(32'hFFFF_FFFC);
        run(8);
        chk("wrap_acc0", accq[0], 32'hFFFF_FFFC);
        chk("wrap_acc1", accq[1], 32'h0000_0000);
        chk("wrap_dlv1", dlv[1], 32'h0000_0000);

        // reset while stale responses are still pending
        do_reset(32'h1C00_0000);
        set_knobs(0, 100, 0, 4, 4);
        fired     = 1'b0;
        force_br2 = 1'b1;
        n = 0;
        while (!(fired && any_stale()) && n < 40) begin
            step();
            n++;
        end
        chk("flush_reached", fired && any_stale(), 1'b1);
        do_reset(32'h1C00_0040);
        set_knobs(0, 100, 0, 1, 2);
        run(12);
        chk("rst_resume_acc", accq[0], 32'h1C00_0040);
        chk("rst_resume_dlv", dlv[0], 32'h1C00_0040);

        // more random traffic from a fresh boot
        set_knobs(20, 70, 4, 1, 5);
        run(2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
